ps2_keyboard: RTL

- PS/2 keyboard receiver feeding the bus keyboard read port (address region 0xD) with a 16-bit key word `xkey`.
- Synchronises and filters the PS/2 clock and data lines, deframes 11-bit frames, and folds E0/F0 prefixes into flags.
- Buffers completed key codes in a small FIFO; the bus pops one entry per CPU read.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_fifo.sv | 47 ++++
 rtl/ps2_keyboard.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: deframer states,
// prefix codes, xkey bit positions and the 10-bit key FIFO entry.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int XKEY_VALID = 15;
  localparam int XKEY_OVF   = 14;
  localparam int XKEY_ERR   = 13;
  localparam int XKEY_EXT   = 9;
  localparam int XKEY_BRK   = 8;
  localparam int KEY_W      = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_entry_t;

  // PS/2 uses odd parity over the data byte plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous key FIFO; an extra pointer bit separates full from empty and the
// head reads as zero while empty.
module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop & ~empty;
  // A full FIFO still accepts a push when the same cycle pops the head.
  assign do_push_s = push & (~full | pop);
  assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= din;
        wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver producing the 16-bit xkey word for bus region 0xD.
// Define PS2_TIMEOUT_EN to resynchronise frames that stall mid-way.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd_ack,
  output logic [15:0] xkey,
  output logic        key_ready
);

  localparam int FW = $clog2(FILT_LEN) + 1;

  logic          ps2_clk_meta_r, ps2_clk_sync_r;
  logic          ps2_data_meta_r, ps2_data_sync_r;
  logic          clk_filt_r, clk_filt_d_r;
  logic [FW-1:0] filt_cnt_r;
  logic          fall_s;

  ps2_state_t    state_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic          byte_done_r;
  logic          frame_err_r;

  logic          ext_r, brk_r, ovf_r, err_r;
  logic          push_s, full_s, empty_s;
  key_entry_t    entry_s;
  key_entry_t    head_s;

  // Two-stage synchronisers and the ps2_clk glitch filter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2_clk_meta_r  <= 1'b0;
      ps2_clk_sync_r  <= 1'b0;
      ps2_data_meta_r <= 1'b0;
      ps2_data_sync_r <= 1'b0;
      clk_filt_r      <= 1'b0;
      clk_filt_d_r    <= 1'b0;
      filt_cnt_r      <= FW'(0);
    end else begin
      ps2_clk_meta_r  <= ps2_clk;
      ps2_clk_sync_r  <= ps2_clk_meta_r;
      ps2_data_meta_r <= ps2_data;
      ps2_data_sync_r <= ps2_data_meta_r;
      clk_filt_d_r    <= clk_filt_r;
      if (ps2_clk_sync_r == clk_filt_r) begin
        filt_cnt_r <= FW'(0);
      end else if (filt_cnt_r == FW'(FILT_LEN - 1)) begin
        clk_filt_r <= ps2_clk_sync_r;
        filt_cnt_r <= FW'(0);
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end
  end

  assign fall_s = clk_filt_d_r & ~clk_filt_r;

`ifdef PS2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_r;
`endif

  // Deframer: start, eight data bits LSB-first, odd parity, stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      parity_r    <= 1'b0;
      byte_done_r <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      to_cnt_r    <= TO_W'(0);
`endif
    end else begin
      byte_done_r <= 1'b0;
      frame_err_r <= 1'b0;
      if (fall_s) begin
        case (state_r)
          IDLE: begin
            if (!ps2_data_sync_r) begin
              state_r   <= DATA;
              bit_cnt_r <= 3'd0;
            end else begin
              state_r <= IDLE;
            end
          end
          DATA: begin
            shift_r <= {ps2_data_sync_r, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) state_r <= PARITY;
            else bit_cnt_r <= bit_cnt_r + 3'd1;
          end
          PARITY: begin
            parity_r <= ps2_data_sync_r;
            state_r  <= STOP;
          end
          STOP: begin
            if (ps2_data_sync_r && odd_parity_ok(shift_r, parity_r)) byte_done_r <= 1'b1;
            else frame_err_r <= 1'b1;
            state_r <= IDLE;
          end
          default: state_r <= IDLE;
        endcase
      end
`ifdef PS2_TIMEOUT_EN
      if (state_r == IDLE || fall_s) begin
        to_cnt_r <= TO_W'(0);
      end else if (to_cnt_r == TO_W'(TIMEOUT_CYC - 1)) begin
        to_cnt_r    <= TO_W'(0);
        state_r     <= IDLE;
        frame_err_r <= 1'b1;
      end else begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
`endif
    end
  end

  assign push_s  = byte_done_r && (shift_r != PS2_EXT) && (shift_r != PS2_BRK);
  assign entry_s = '{ext: ext_r, brk: brk_r, code: shift_r};

  // Prefix flags and the sticky status bits; a new event wins over a clearing read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_r <= 1'b0;
      brk_r <= 1'b0;
      ovf_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      if (frame_err_r) begin
        ext_r <= 1'b0;
        brk_r <= 1'b0;
      end else if (byte_done_r) begin
        if (shift_r == PS2_EXT) begin
          ext_r <= 1'b1;
        end else if (shift_r == PS2_BRK) begin
          brk_r <= 1'b1;
        end else begin
          ext_r <= 1'b0;
          brk_r <= 1'b0;
        end
      end
      if (frame_err_r) err_r <= 1'b1;
      else if (rd_ack) err_r <= 1'b0;
      if (push_s && full_s && !rd_ack) ovf_r <= 1'b1;
      else if (rd_ack) ovf_r <= 1'b0;
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (rd_ack),
    .din   (entry_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign xkey      = {~empty_s, ovf_r, err_r, 3'b000, head_s};
  assign key_ready = ~empty_s;

endmodule
